btn_debounce: RTL and testbench

- Input conditioner placed directly upstream of the processor debug unit (PDU).
- Takes raw board inputs (run, step, valid and the five in[] switches/buttons) and produces clean, synchronised levels plus one-cycle rise/fall pulses.
- The PDU consumes these in place of raw pins, so it can rely on glitch-free levels and use the pulses directly for stepping and for the pre/next and valid counters.
- Each channel is independent: a 2-flop synchroniser followed by a stability counter.

---
 rtl/btn_debounce.sv | 63 ++++++
 tb/tb_btn_debounce.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
// Per-channel 2-flop synchroniser plus stability counter; db follows raw STABLE_CNT+2 edges after a steady change.
// Registered rise/fall pulses accompany each db flip; no handshake, the block never stalls.
module btn_debounce #(
  parameter int              N          = 8,
  parameter int              STABLE_CNT = 1000000,
  parameter int              CNT_W      = 20,
  parameter logic [N-1:0]    INIT       = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [N-1:0]     db_nxt;
  logic [CNT_W-1:0] cnt     [N];
  logic [CNT_W-1:0] cnt_nxt [N];

  // Any agreement between sync2 and db discards the run; only an unbroken run flips db.
  always_comb begin
    db_nxt = db;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != db[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= INIT;
      sync2 <= INIT;
      db    <= INIT;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db    <= db_nxt;
      rise  <= db_nxt & ~db;
      fall  <= ~db_nxt & db;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
`timescale 1ns/1ps
// Directed bench for btn_debounce at N=8, STABLE_CNT=4, CNT_W=3, INIT=0.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw;
  logic [7:0] db;
  logic [7:0] rise;
  logic [7:0] fall;

  int tests = 0;
  int fails = 0;

  logic       mon_en = 1'b0;
  logic       mon_primed = 1'b0;
  logic [7:0] prev_db;

  btn_debounce #(
    .N         (8),
    .STABLE_CNT(4),
    .CNT_W     (3),
    .INIT      (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .raw (raw),
    .db  (db),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse invariants while random patterns run: pulses must equal the db edges seen by the bench.
  always @(posedge clk) begin
    if (mon_en) begin
      #2;
      if (!mon_primed) begin
        prev_db    = db;
        mon_primed = 1'b1;
      end else begin
        chk("mon_rise_and_fall", 32'(rise & fall), 32'h0);
        chk("mon_rise_edge", 32'(rise), 32'(db & ~prev_db));
        chk("mon_fall_edge", 32'(fall), 32'(~db & prev_db));
        prev_db = db;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int          exp_cnt [12] = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 3, 0, 0};
    logic        bounce  [6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  pat;
    int          hold;

    // 1. reset state and release with raw already high
    rst = 1'b1;
    raw = 8'hFF;
    tick();
    tick();
    chk("rst_db", 32'(db), 32'h00);
    chk("rst_rise", 32'(rise), 32'h00);
    chk("rst_fall", 32'(fall), 32'h00);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("rel_db_e%0d", e), 32'(db), 32'h00);
      chk($sformatf("rel_rise_e%0d", e), 32'(rise), 32'h00);
    end
    tick();
    chk("rel_db_e6", 32'(db), 32'hFF);
    chk("rel_rise_e6", 32'(rise), 32'hFF);
    tick();
    chk("rel_db_e7", 32'(db), 32'hFF);
    chk("rel_rise_e7", 32'(rise), 32'h00);

    // bring everything back to 0
    raw = 8'h00;
    for (int e = 1; e <= 5; e++) tick();
    tick();
    chk("clr_db", 32'(db), 32'h00);
    chk("clr_fall", 32'(fall), 32'hFF);
    tick();
    chk("clr_fall_end", 32'(fall), 32'h00);

    // 2a. 3-edge glitch is rejected
    raw = 8'h01;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("g3_db_e%0d", e), 32'(db), 32'h00);
    end
    raw = 8'h00;
    for (int e = 4; e <= 8; e++) begin
      tick();
      chk($sformatf("g3_db_e%0d", e), 32'(db), 32'h00);
      chk($sformatf("g3_rise_e%0d", e), 32'(rise), 32'h00);
    end

    // 2b. 4-edge pulse is accepted, then falls back
    raw = 8'h01;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("g4_db_e%0d", e), 32'(db), 32'h00);
    end
    raw = 8'h00;
    tick();
    chk("g4_db_e5", 32'(db), 32'h00);
    tick();
    chk("g4_db_e6", 32'(db), 32'h01);
    chk("g4_rise_e6", 32'(rise), 32'h01);
    tick();
    chk("g4_rise_e7", 32'(rise), 32'h00);
    tick();
    tick();
    chk("g4_db_e9", 32'(db), 32'h01);
    tick();
    chk("g4_db_e10", 32'(db), 32'h00);
    chk("g4_fall_e10", 32'(fall), 32'h01);
    tick();
    chk("g4_fall_e11", 32'(fall), 32'h00);

    // 3. bounce on channel 2: counter clears on each reversal
    for (int e = 1; e <= 12; e++) begin
      raw[2] = (e <= 6) ? bounce[e-1] : 1'b1;
      tick();
      chk($sformatf("bnc_cnt_e%0d", e), 32'(dut.cnt[2]), 32'(exp_cnt[e-1]));
      chk($sformatf("bnc_db_e%0d", e), 32'(db[2]), (e >= 11) ? 32'h1 : 32'h0);
      chk($sformatf("bnc_rise_e%0d", e), 32'(rise[2]), (e == 11) ? 32'h1 : 32'h0);
    end

    // 4. fall on channel 1 and rise on channel 7 together
    raw = 8'h03;
    for (int e = 1; e <= 8; e++) tick();
    chk("ind_db_init", 32'(db), 32'h03);
    raw = 8'h81;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("ind_db_e%0d", e), 32'(db), 32'h03);
      chk($sformatf("ind_pulse_e%0d", e), 32'({rise, fall}), 32'h0);
    end
    tick();
    chk("ind_db_e6", 32'(db), 32'h81);
    chk("ind_rise_e6", 32'(rise), 32'h80);
    chk("ind_fall_e6", 32'(fall), 32'h02);
    tick();
    chk("ind_pulse_e7", 32'({rise, fall}), 32'h0);
    chk("ind_db_e7", 32'(db), 32'h81);

    // 5. reset in the middle of a count
    raw = 8'h89;
    for (int e = 1; e <= 4; e++) tick();
    chk("mid_cnt3", 32'(dut.cnt[3]), 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_db", 32'(db), 32'h00);
    chk("mid_rst_pulse", 32'({rise, fall}), 32'h0);
    chk("mid_rst_cnt3", 32'(dut.cnt[3]), 32'h0);
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("mid_db_e%0d", e), 32'(db), 32'h00);
      chk($sformatf("mid_pulse_e%0d", e), 32'({rise, fall}), 32'h0);
    end
    tick();
    chk("mid_db_e6", 32'(db), 32'h89);
    chk("mid_rise_e6", 32'(rise), 32'h89);
    tick();
    chk("mid_rise_e7", 32'(rise), 32'h00);

    // 6. random stable patterns with pulse invariants checked every cycle
    mon_en = 1'b1;
    for (int p = 0; p < 800; p++) begin
      pat  = 8'($urandom);
      raw  = pat;
      hold = 10 + int'($urandom_range(0, 3));
      for (int e = 0; e < hold; e++) tick();
      chk($sformatf("rnd_db_p%0d", p), 32'(db), 32'(pat));
    end
    mon_en = 1'b0;
    #10;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
